// File: rtl/act_sigmoid_scheduler_pkg.sv
// rtl/act_sigmoid_scheduler_pkg.sv - shared types and constants for the sigmoid unit scheduler
package act_sched_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam int QN_DEF = 6;
  localparam int QM_DEF = 11;
  localparam int W      = QN_DEF + QM_DEF + 1;
  localparam int ONE_Q  = 2048;
  localparam int ZERO_Q = 0;

  // Never returns less than 1 so single-value counters still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/act_sigmoid_scheduler_if.sv
// rtl/act_sigmoid_scheduler_if.sv - requester/response bundle between gate requesters and the scheduler
interface act_sigmoid_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 18
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_operand;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_result;
  logic              rsp_ready;

  modport master (
    output req_valid, req_operand, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_operand, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/act_sigmoid_scheduler_rr_arbiter.sv
// rtl/act_sigmoid_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);
  int k;

  // Scan from the farthest offset back to ptr so the nearest asserted index wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    k     = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      k = (int'(ptr) + off) % NREQ;
      if (req[k]) begin
        grant = NREQ'(1) << k;
        idx   = PW'(k);
      end
    end
  end
endmodule

// File: rtl/act_sigmoid_scheduler.sv
// rtl/act_sigmoid_scheduler.sv - round-robin sharing of one fixed-latency sigmoid unit
module act_sigmoid_scheduler
  import act_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int QN   = QN_DEF,
  parameter int QM   = QM_DEF,
  parameter int LAT  = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  act_sigmoid_scheduler_if.slave bus,
  output logic                   act_clear,
  output logic [QN+QM:0]         act_operand,
  input  logic [QN+QM:0]         act_result,
  output logic                   busy
);
  localparam int DW = QN + QM + 1;
  localparam int PW = clog2(NREQ);
  localparam int CW = clog2(LAT);

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] arb_grant;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Accept strobe is only offered while idle and out of reset.
  assign bus.req_ready = (state == IDLE && !reset) ? arb_grant : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      gnt            <= '0;
      cnt            <= '0;
      act_operand    <= '0;
      act_clear      <= 1'b1;
      busy           <= 1'b0;
      bus.rsp_valid  <= '0;
      bus.rsp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            act_operand <= bus.req_operand[arb_idx*DW +: DW];
            gnt         <= arb_idx;
            rr_ptr      <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            act_clear   <= 1'b1;
            busy        <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt       <= CW'(LAT - 1);
          act_clear <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            bus.rsp_result <= act_result;
            bus.rsp_valid  <= NREQ'(1) << gnt;
            act_clear      <= 1'b1;
            state          <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= '0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_act_sigmoid_scheduler.sv
// tb/tb_act_sigmoid_scheduler.sv - randomized and directed checks of the sigmoid scheduler against a timing/arbitration model
module tb_act_sigmoid_scheduler;
  import act_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  act_sigmoid_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();
  logic         act_clear;
  logic         busy;
  logic [W-1:0] act_operand;
  logic [W-1:0] act_result;

  act_sigmoid_scheduler #(.NREQ(NREQ), .QN(QN_DEF), .QM(QM_DEF), .LAT(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .act_clear   (act_clear),
    .act_operand (act_operand),
    .act_result  (act_result),
    .busy        (busy)
  );

  function automatic logic [W-1:0] sig_ref(input logic [W-1:0] x);
    int xi;
    xi = int'($signed(x));
    if (xi >= 2 * ONE_Q) return W'(ONE_Q);
    if (xi <= -2 * ONE_Q) return W'(ZERO_Q);
    return W'(ONE_Q / 2 + xi / 4);
  endfunction

  // Unit stub: correct value only on the LAT-th cycle after clear drops.
  int stub_cnt;
  always_ff @(posedge clock) begin
    if (act_clear) stub_cnt <= 0;
    else if (stub_cnt < 100) stub_cnt <= stub_cnt + 1;
  end
  assign act_result = (!act_clear && stub_cnt == LAT - 1) ? sig_ref(act_operand) : ~sig_ref(act_operand);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0: return W'(-8192);
      1: return W'(0);
      2: return W'(1024);
      3: return W'(4096);
      4: return W'(8192);
      default: return W'($urandom);
    endcase
  endfunction

  function automatic int predict(input logic [NREQ-1:0] pend, input int p);
    for (int off = 0; off < NREQ; off++)
      if (pend[(p + off) % NREQ]) return (p + off) % NREQ;
    return -1;
  endfunction

  logic [NREQ-1:0] v = '0;
  logic [W-1:0]    ops [NREQ];
  logic [NREQ-1:0] granted_obs = '0;
  logic [NREQ-1:0] rr_mask = '0;
  int p_req = 0, p_drop = 0, p_ready = 16;
  bit fair_mode = 0;

  int ptr_m = 0, t_grant = 0, g_m = 0, cyc = 0, last_g = -1;
  bit in_flight = 0;
  logic [W-1:0] op_m;

  task automatic tick(input bit rst);
    int eg, k;
    reset = rst;
    for (int i = 0; i < NREQ; i++) begin
      if (granted_obs[i]) begin
        v[i]   = rr_mask[i];
        ops[i] = rand_op();
      end else if (v[i]) begin
        if ($urandom_range(0, 15) < p_drop) v[i] = 1'b0;
      end else if ($urandom_range(0, 15) < p_req) begin
        v[i]   = 1'b1;
        ops[i] = rand_op();
      end
      bus.req_operand[i*W +: W] = ops[i];
    end
    bus.req_valid = v;
    bus.rsp_ready = ($urandom_range(0, 15) < p_ready);
    @(negedge clock);
    cyc++;
    granted_obs = bus.req_ready;
    if (rst) begin
      check("ready_in_reset", 32'(bus.req_ready), 32'(0));
      in_flight   = 0;
      ptr_m       = 0;
      last_g      = -1;
      granted_obs = '0;
    end else if (!in_flight) begin
      eg = predict(v, ptr_m);
      check("req_ready", 32'(bus.req_ready), (eg < 0) ? 32'(0) : 32'(1) << eg);
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_rsp_valid", 32'(bus.rsp_valid), 32'(0));
      check("idle_clear", 32'(act_clear), 32'(1));
      if (eg >= 0) begin
        if (fair_mode && last_g >= 0) check("fair_alt", 32'(bus.req_ready), 32'(1) << (NREQ - 1 - last_g));
        in_flight = 1;
        t_grant   = cyc;
        g_m       = eg;
        op_m      = ops[eg];
        ptr_m     = (eg + 1) % NREQ;
        last_g    = eg;
      end
    end else begin
      k = cyc - t_grant;
      check("busy_ready", 32'(bus.req_ready), 32'(0));
      check("busy_flag", 32'(busy), 32'(1));
      check("operand_hold", 32'(act_operand), 32'(op_m));
      if (k == 1) check("clear_launch", 32'(act_clear), 32'(1));
      else if (k <= LAT + 1) check("clear_wait", 32'(act_clear), 32'(0));
      if (k < LAT + 2) begin
        check("rsp_early", 32'(bus.rsp_valid), 32'(0));
      end else begin
        check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << g_m);
        check("rsp_result", 32'(bus.rsp_result), 32'(sig_ref(op_m)));
        if (bus.rsp_ready) in_flight = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    v           = '0;
    granted_obs = '0;
    tick(1);
    tick(1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) ops[i] = '0;
    bus.req_valid   = '0;
    bus.req_operand = '0;
    bus.rsp_ready   = 1'b1;
    @(posedge clock);
    #1;
    do_reset();
    check("rst_rsp_result", 32'(bus.rsp_result), 32'(0));
    check("rst_act_operand", 32'(act_operand), 32'(0));
    check("rst_act_clear", 32'(act_clear), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));

    // single request, saturating operand
    v[2] = 1'b1; ops[2] = W'(4096);
    run(14);

    // all four at once from rr_ptr=0
    do_reset();
    v = 4'b1111;
    ops[0] = W'(-8192); ops[1] = W'(0); ops[2] = W'(1024); ops[3] = W'(8192);
    run(40);

    // fairness between 0 and 3 kept continuously valid
    do_reset();
    rr_mask = 4'b1001; fair_mode = 1;
    v = 4'b1001; ops[0] = rand_op(); ops[3] = rand_op();
    run(40);
    rr_mask = '0; fair_mode = 0;

    // backpressure for 20 RESP cycles with another requester waiting
    do_reset();
    p_ready = 0;
    v[1] = 1'b1; ops[1] = rand_op();
    tick(0);
    v[0] = 1'b1; ops[0] = rand_op();
    run(27);
    p_ready = 16;
    run(12);

    // reset in the middle of WAIT with requesters pending
    do_reset();
    rr_mask = 4'b0010;
    v = 4'b0110; ops[1] = rand_op(); ops[2] = rand_op();
    run(4);
    tick(1);
    rr_mask = '0;
    run(24);

    // randomized traffic with random backpressure and occasional reset
    do_reset();
    p_req = 4; p_drop = 1; p_ready = 10;
    for (int i = 0; i < 3000; i++) tick($urandom_range(0, 499) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
